// File: rtl/dff_sre.sv
// dff_sre: width-parameterizable D flip-flop with synchronous reset,
// synchronous set, clock enable and a complementary output.
//
// Ports
//   clk     in   rising-edge clock, sole timing reference
//   reset   in   synchronous active-high clear (highest priority)
//   set     in   synchronous active-high preset
//   enable  in   active-high load enable for d
//   d       in   [WIDTH-1:0] data input
//   q       out  [WIDTH-1:0] registered state
//   q_n     out  [WIDTH-1:0] bitwise complement of q
//
// Priority at each rising edge: reset > set > enable > hold.

// Per-bit storage cell. One instance per bit of the top-level vector.
module dff_sre_bit (
   input  logic clk,
   input  logic reset,
   input  logic set,
   input  logic enable,
   input  logic d,
   output logic q
);

   // Two-state storage: starts at 0 in simulation and can never hold X,
   // so the outputs are defined even before the first reset edge.
   bit state;

   always_ff @(posedge clk) begin
      if (reset)       state <= 1'b0;
      else if (set)    state <= 1'b1;
      else if (enable) state <= d;
   end

   assign q = state;

endmodule

module dff_sre #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             set,
   input  logic             enable,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_n
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      dff_sre_bit u_bit (
         .clk    (clk),
         .reset  (reset),
         .set    (set),
         .enable (enable),
         .d      (d[i]),
         .q      (q[i])
      );
   end

   // Derived from q itself, never from separate state, so q_n == ~q always.
   assign q_n = ~q;

endmodule

// File: tb/tb_dff_sre.sv
// tb_dff_sre: directed-vector bench for dff_sre. Drives a 1-bit instance
// (default width) and a 4-bit instance from the same controls, checks q and
// q_n against hand-computed values one time unit after each rising edge.
`timescale 1ns/1ps
module tb_dff_sre;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       set = 1'b0;
   logic       enable = 1'b0;
   logic       d = 1'b0;
   logic [3:0] d4 = 4'h0;
   logic       q, q_n;
   logic [3:0] q4, q4_n;

   int n_cmp = 0;
   int n_bad = 0;

   always #10 clk = ~clk;

   dff_sre u_dut (
      .clk    (clk),
      .reset  (reset),
      .set    (set),
      .enable (enable),
      .d      (d),
      .q      (q),
      .q_n    (q_n)
   );

   dff_sre #(.WIDTH(4)) u_dut4 (
      .clk    (clk),
      .reset  (reset),
      .set    (set),
      .enable (enable),
      .d      (d4),
      .q      (q4),
      .q_n    (q4_n)
   );

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge and settle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Check both outputs of the 1-bit instance.
   task automatic chk1(input string tag, input logic exp_q);
      chk({tag, ".q"},   {3'b0, q},   {3'b0, exp_q});
      chk({tag, ".q_n"}, {3'b0, q_n}, {3'b0, ~exp_q});
   endtask

   task automatic chk4(input string tag, input logic [3:0] exp_q);
      chk({tag, ".q4"},   q4,   exp_q);
      chk({tag, ".q4_n"}, q4_n, ~exp_q);
   endtask

   initial begin
      // Power-up: outputs defined before any edge.
      #1;
      chk1("powerup", 1'b0);
      chk4("powerup", 4'h0);

      // Idle, all inputs low for 100 ns.
      for (int i = 0; i < 5; i++) begin
         step();
         chk1("idle", 1'b0);
      end

      // Reset held.
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk1("reset", 1'b0);
         chk4("reset", 4'h0);
      end

      // Set held.
      reset = 1'b0; set = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk1("set", 1'b1);
         chk4("set", 4'hF);
      end

      // Load 0, then load 1 (not visible before the edge).
      set = 1'b0; enable = 1'b1; d = 1'b0; d4 = 4'hA;
      step();
      chk1("load0", 1'b0);
      chk4("loadA", 4'hA);
      d = 1'b1; d4 = 4'h5;
      #5;
      chk1("load1_pre", 1'b0);
      chk4("load5_pre", 4'hA);
      step();
      chk1("load1", 1'b1);
      chk4("load5", 4'h5);

      // Hold: enable low, d toggles.
      enable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         d = i[0]; d4 = 4'(i * 3);
         step();
         chk1("hold", 1'b1);
         chk4("hold", 4'h5);
      end

      // reset and set together -> reset wins.
      reset = 1'b1; set = 1'b1;
      step();
      chk1("rst_set", 1'b0);
      chk4("rst_set", 4'h0);

      // set and enable with d=0 -> set wins.
      reset = 1'b0; set = 1'b1; enable = 1'b1; d = 1'b0; d4 = 4'h0;
      step();
      chk1("set_en", 1'b1);
      chk4("set_en", 4'hF);

      // One-cycle reset pulse while loading 1, then load resumes.
      set = 1'b0; enable = 1'b1; d = 1'b0; d4 = 4'h6;
      step();
      chk1("pre_pulse", 1'b0);
      chk4("pre_pulse", 4'h6);
      reset = 1'b1; d = 1'b1; d4 = 4'h9;
      step();
      chk1("rst_pulse", 1'b0);
      chk4("rst_pulse", 4'h0);
      reset = 1'b0;
      step();
      chk1("after_pulse", 1'b1);
      chk4("after_pulse", 4'h9);

      // Mid-cycle glitch on controls has no effect between edges.
      #3; reset = 1'b1; #2; reset = 1'b0; set = 1'b0; enable = 1'b0;
      #2;
      chk1("glitch", 1'b1);
      chk4("glitch", 4'h9);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
